// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter that shares the ULPI PHY register-access port among NUM_REQ requesters.
// It drives one transaction at a time, retries on REG_FAIL or timeout, and acknowledges the owner.
module ulpi_reg_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 CLK_60M,
  input  logic                 RST_S_USB,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ-1:0]   REQ_RW,
  input  logic [6*NUM_REQ-1:0] REQ_ADDR,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]   ACK_DONE,
  output logic [NUM_REQ-1:0]   ACK_FAIL,
  output logic [7:0]           ACK_DATA,
  output logic [2:0]           GNT_ID,
  output logic                 BUSY,
  output logic                 REG_EN,
  output logic                 REG_RW,
  output logic [5:0]           REG_ADDR,
  output logic [7:0]           REG_DATA_I,
  input  logic                 REG_DONE,
  input  logic                 REG_FAIL,
  input  logic                 READY,
  input  logic [7:0]           REG_DATA_O
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  last_gnt_q, last_gnt_d;
  logic        rw_q, rw_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic        ok_q, ok_d;
  logic [7:0]  ack_data_q, ack_data_d;

  logic        hi_found, lo_found, win_valid;
  logic [2:0]  hi_id, lo_id, win_id;
  logic        win_rw;
  logic [5:0]  win_addr;
  logic [7:0]  win_data;

  // Round-robin search: requesters above last_gnt come first, then wrap to the lowest index.
  // Scanning downward lets the last hit in each half be the lowest index of that half.
  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        if (3'(i) > last_gnt_q) begin
          hi_found = 1'b1;
          hi_id    = 3'(i);
        end else begin
          lo_found = 1'b1;
          lo_id    = 3'(i);
        end
      end
    end
    win_valid = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;

    win_rw   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == win_id) begin
        win_rw   = REQ_RW[i];
        win_addr = REQ_ADDR[6*i +: 6];
        win_data = REQ_DATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    ok_d       = ok_q;
    ack_data_d = ack_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (READY && win_valid) begin
          gnt_d      = win_id;
          last_gnt_d = win_id;
          rw_d       = win_rw;
          addr_d     = win_addr;
          data_d     = win_data;
          retry_d    = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d = '0;
        if (!READY) begin
          ok_d    = 1'b0;
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        // Losing READY aborts without retry and outranks a coincident DONE.
        if (!READY) begin
          ok_d    = 1'b0;
          state_d = S_ACK;
        end else if (REG_DONE) begin
          ok_d = 1'b1;
          if (!rw_q) ack_data_d = REG_DATA_O;
          state_d = S_ACK;
        end else if (REG_FAIL || (tmo_q == TMO_LAST)) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_ISSUE;
          end else begin
            ok_d    = 1'b0;
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values in parallel.
  always_ff @(posedge CLK_60M) begin
    if (RST_S_USB) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_gnt_q <= 3'(NUM_REQ - 1);
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      ok_q       <= 1'b0;
      ack_data_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      ok_q       <= ok_d;
      ack_data_q <= ack_data_d;
    end
  end

  // The ULPI bus is driven only during ISSUE, and REG_EN drops with READY.
  assign REG_EN     = (state_q == S_ISSUE) && READY;
  assign REG_RW     = (state_q == S_ISSUE) && rw_q;
  assign REG_ADDR   = (state_q == S_ISSUE) ? addr_q : 6'd0;
  assign REG_DATA_I = (state_q == S_ISSUE) ? data_q : 8'd0;

  assign BUSY     = (state_q != S_IDLE);
  assign GNT_ID   = gnt_q;
  assign ACK_DATA = ack_data_q;

  always_comb begin
    ACK_DONE = '0;
    ACK_FAIL = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state_q == S_ACK) && (3'(i) == gnt_q)) begin
        ACK_DONE[i] = ok_q;
        ACK_FAIL[i] = !ok_q;
      end
    end
  end

  a_en_single : assert property (@(posedge CLK_60M) disable iff (RST_S_USB) REG_EN |=> !REG_EN);
  a_ack_onehot : assert property (@(posedge CLK_60M) disable iff (RST_S_USB) $onehot0(ACK_DONE | ACK_FAIL));

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Directed bench for ulpi_reg_arbiter: a simple ULPI responder answers each REG_EN after a
// fixed latency; every expected value below is hand-computed from the cycle timing.
module tb_ulpi_reg_arbiter;

  localparam int N = 4;

  logic           CLK_60M = 1'b0;
  logic           RST_S_USB;
  logic [N-1:0]   REQ;
  logic [N-1:0]   REQ_RW;
  logic [6*N-1:0] REQ_ADDR;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   ACK_DONE;
  logic [N-1:0]   ACK_FAIL;
  logic [7:0]     ACK_DATA;
  logic [2:0]     GNT_ID;
  logic           BUSY;
  logic           REG_EN;
  logic           REG_RW;
  logic [5:0]     REG_ADDR;
  logic [7:0]     REG_DATA_I;
  logic           REG_DONE;
  logic           REG_FAIL;
  logic           READY;
  logic [7:0]     REG_DATA_O;

  ulpi_reg_arbiter #(
    .NUM_REQ    (N),
    .MAX_RETRY  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .CLK_60M   (CLK_60M),
    .RST_S_USB (RST_S_USB),
    .REQ       (REQ),
    .REQ_RW    (REQ_RW),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .ACK_DONE  (ACK_DONE),
    .ACK_FAIL  (ACK_FAIL),
    .ACK_DATA  (ACK_DATA),
    .GNT_ID    (GNT_ID),
    .BUSY      (BUSY),
    .REG_EN    (REG_EN),
    .REG_RW    (REG_RW),
    .REG_ADDR  (REG_ADDR),
    .REG_DATA_I(REG_DATA_I),
    .REG_DONE  (REG_DONE),
    .REG_FAIL  (REG_FAIL),
    .READY     (READY),
    .REG_DATA_O(REG_DATA_O)
  );

  always #5 CLK_60M = ~CLK_60M;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls, written by the main sequence only while no response is pending.
  bit       resp_on   = 1'b1;
  int       resp_lat  = 3;
  int       fail_left = 0;
  logic [7:0] rd_data = 8'h00;

  // Monitor results.
  int       resp_cd     = 0;
  int       mon_cyc     = 0;
  int       en_cnt      = 0;
  int       en_last_cyc = 0;
  int       en_gap      = 0;
  int       en_consec   = 0;
  int       bus_dirty   = 0;
  int       ack_cnt     = 0;
  bit       prev_en     = 1'b0;
  logic     en_rw       = 1'b0;
  logic [5:0] en_addr   = '0;
  logic [7:0] en_data   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [5:0] a, input logic [7:0] d);
    REQ_RW[i]         = rw;
    REQ_ADDR[i*6 +: 6] = a;
    REQ_DATA[i*8 +: 8] = d;
  endtask

  // Counts falling edges until some acknowledge is visible; an expired bound is a failed check.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge CLK_60M);
      n++;
    end while (((ACK_DONE | ACK_FAIL) == '0) && (n < 200));
    if ((ACK_DONE | ACK_FAIL) == '0) check("ack_wait_bound", 64'(n), 64'd0);
  endtask

  // ULPI responder and bus monitor, sampled on the falling edge.
  initial begin
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    REG_DATA_O = 8'h00;
    forever begin
      @(negedge CLK_60M);
      mon_cyc++;
      REG_DONE   = 1'b0;
      REG_FAIL   = 1'b0;
      REG_DATA_O = 8'h00;
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          if (fail_left > 0) begin
            REG_FAIL = 1'b1;
            fail_left--;
          end else begin
            REG_DONE   = 1'b1;
            REG_DATA_O = rd_data;
          end
        end
      end
      if (REG_EN) begin
        if (prev_en) en_consec++;
        en_gap      = mon_cyc - en_last_cyc;
        en_last_cyc = mon_cyc;
        en_cnt++;
        en_rw   = REG_RW;
        en_addr = REG_ADDR;
        en_data = REG_DATA_I;
        if (resp_on) resp_cd = resp_lat;
      end else if (READY && (REG_RW || (REG_ADDR != 6'd0) || (REG_DATA_I != 8'd0))) begin
        bus_dirty++;
      end
      prev_en = REG_EN;
      if ((ACK_DONE | ACK_FAIL) != '0) ack_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int en_base;
    int ack_base;

    RST_S_USB = 1'b1;
    READY     = 1'b1;
    REQ       = '0;
    REQ_RW    = '0;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
    repeat (3) @(negedge CLK_60M);
    check("rst_outputs", 64'({ACK_DONE, ACK_FAIL, ACK_DATA, GNT_ID, BUSY,
                              REG_EN, REG_RW, REG_ADDR, REG_DATA_I}), 64'd0);
    RST_S_USB = 1'b0;
    @(negedge CLK_60M);
    check("idle_busy", 64'(BUSY), 64'd0);

    // Single write from requester 1; other requesters carry distinct junk fields.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 6'(8'h30 + i), 8'(8'hE0 + i));
    set_req(1, 1'b1, 6'h04, 8'h66);
    REQ = 4'b0010;
    @(negedge CLK_60M);
    check("wr_issue_en", 64'({REG_EN, REG_RW, REG_ADDR, REG_DATA_I}), 64'({1'b1, 1'b1, 6'h04, 8'h66}));
    check("wr_gnt", 64'(GNT_ID), 64'd1);
    wait_ack(n);
    check("wr_latency", 64'(n), 64'd4);
    check("wr_ack", 64'({ACK_DONE, ACK_FAIL}), 64'({4'b0010, 4'b0000}));
    REQ = '0;
    @(negedge CLK_60M);
    check("wr_ack_pulse", 64'({ACK_DONE, BUSY}), 64'd0);

    // Read from requester 2 returns 0xA5.
    set_req(2, 1'b0, 6'h16, 8'h00);
    rd_data = 8'hA5;
    REQ = 4'b0100;
    wait_ack(n);
    check("rd_latency", 64'(n), 64'd5);
    check("rd_ack", 64'({ACK_DONE, ACK_DATA, GNT_ID}), 64'({4'b0100, 8'hA5, 3'd2}));
    check("rd_bus", 64'({en_rw, en_addr}), 64'({1'b0, 6'h16}));
    REQ = '0;
    @(negedge CLK_60M);
    check("rd_data_hold", 64'(ACK_DATA), 64'hA5);

    // A write must leave ACK_DATA alone even though REG_DATA_O carries other data.
    set_req(3, 1'b1, 6'h21, 8'h5C);
    rd_data = 8'h3C;
    REQ = 4'b1000;
    wait_ack(n);
    check("wr_keeps_data", 64'({ACK_DONE, ACK_DATA}), 64'({4'b1000, 8'hA5}));
    REQ = '0;
    @(negedge CLK_60M);

    // Fairness from reset: all four held, each cleared on its acknowledge.
    RST_S_USB = 1'b1;
    repeat (2) @(negedge CLK_60M);
    RST_S_USB = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(8 + i), 8'(16 + i));
    REQ = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_ack(n);
      check($sformatf("fair_order_%0d", k), 64'(ACK_DONE), 64'd1 << k);
      // Back-to-back: ACK, IDLE, ISSUE, three WAIT cycles, then ACK again.
      check($sformatf("fair_gap_%0d", k), 64'(n), (k == 0) ? 64'd5 : 64'd6);
      REQ[k] = 1'b0;
    end
    REQ[0] = 1'b1;
    wait_ack(n);
    check("fair_regrant_0", 64'({ACK_DONE, 5'(n)}), 64'({4'b0001, 5'd6}));
    REQ = '0;
    @(negedge CLK_60M);

    // FAIL on every attempt: first try plus three retries, then fail. Fields change after grant.
    fail_left = 100;
    en_base   = en_cnt;
    set_req(3, 1'b1, 6'h2A, 8'hC3);
    REQ = 4'b1000;
    @(negedge CLK_60M);
    set_req(3, 1'b0, 6'h01, 8'h00);
    wait_ack(n);
    check("retry_latency", 64'(n), 64'd16);
    check("retry_en_count", 64'(en_cnt - en_base), 64'd4);
    check("retry_ack", 64'({ACK_DONE, ACK_FAIL}), 64'({4'b0000, 4'b1000}));
    check("retry_latched", 64'({en_rw, en_addr, en_data}), 64'({1'b1, 6'h2A, 8'hC3}));
    REQ = '0;
    fail_left = 0;
    @(negedge CLK_60M);

    // FAIL once, then DONE on the second attempt.
    fail_left = 1;
    en_base   = en_cnt;
    set_req(0, 1'b1, 6'h05, 8'h99);
    REQ = 4'b0001;
    wait_ack(n);
    check("retry_ok_latency", 64'(n), 64'd9);
    check("retry_ok_en_count", 64'(en_cnt - en_base), 64'd2);
    check("retry_ok_ack", 64'({ACK_DONE, ACK_FAIL}), 64'({4'b0001, 4'b0000}));
    REQ = '0;
    @(negedge CLK_60M);

    // Timeout with no response: eight WAIT cycles plus the ISSUE cycle between REG_EN pulses.
    resp_on = 1'b0;
    en_base = en_cnt;
    set_req(1, 1'b1, 6'h3E, 8'h81);
    REQ = 4'b0010;
    wait_ack(n);
    check("tmo_latency", 64'(n), 64'd37);
    check("tmo_en_count", 64'(en_cnt - en_base), 64'd4);
    check("tmo_en_gap", 64'(en_gap), 64'd9);
    check("tmo_ack", 64'({ACK_DONE, ACK_FAIL}), 64'({4'b0000, 4'b0010}));
    REQ = '0;
    resp_on = 1'b1;
    @(negedge CLK_60M);

    // READY drops in the same cycle REG_DONE arrives: the owner gets fail.
    set_req(2, 1'b1, 6'h12, 8'h34);
    REQ = 4'b0100;
    repeat (4) @(negedge CLK_60M);
    READY = 1'b0;
    @(negedge CLK_60M);
    check("rdy_drop_ack", 64'({ACK_DONE, ACK_FAIL}), 64'({4'b0000, 4'b0100}));
    REQ     = 4'b0101;
    en_base = en_cnt;
    repeat (5) @(negedge CLK_60M);
    check("rdy_low_no_grant", 64'({BUSY, 8'(en_cnt - en_base)}), 64'd0);
    READY = 1'b1;
    wait_ack(n);
    // last_gnt is 2, so the search runs 3 then 0.
    check("rdy_back_grant", 64'({ACK_DONE, 5'(n)}), 64'({4'b0001, 5'd5}));
    REQ = '0;
    @(negedge CLK_60M);

    // Reset in the middle of WAIT for requester 1.
    resp_on = 1'b0;
    set_req(1, 1'b1, 6'h07, 8'h70);
    REQ = 4'b0010;
    repeat (3) @(negedge CLK_60M);
    ack_base  = ack_cnt;
    RST_S_USB = 1'b1;
    @(negedge CLK_60M);
    check("mid_rst_outputs", 64'({ACK_DONE, ACK_FAIL, ACK_DATA, GNT_ID, BUSY,
                                  REG_EN, REG_RW, REG_ADDR, REG_DATA_I}), 64'd0);
    @(negedge CLK_60M);
    check("mid_rst_no_ack", 64'(ack_cnt - ack_base), 64'd0);
    RST_S_USB = 1'b0;
    resp_on   = 1'b1;
    set_req(0, 1'b1, 6'h0A, 8'h0B);
    set_req(3, 1'b1, 6'h0C, 8'h0D);
    REQ = 4'b1001;
    wait_ack(n);
    check("post_rst_first", 64'({ACK_DONE, 5'(n)}), 64'({4'b0001, 5'd5}));
    REQ = '0;
    @(negedge CLK_60M);

    check("en_never_consecutive", 64'(en_consec), 64'd0);
    check("bus_zero_outside_issue", 64'(bus_dirty), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
